// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter and its ALU.
package alu_share_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 20;

  typedef logic [1:0] aluCtrlT;

  localparam aluCtrlT ALU_ADD = 2'b00;
  localparam aluCtrlT ALU_OR  = 2'b01;
  localparam aluCtrlT ALU_AND = 2'b10;
  localparam aluCtrlT ALU_NOT = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_ula.sv
// Combinational ALU: add (carry dropped), or, and, not opA.
module ula
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] result
);

  // Select the operation; opB is unused for ALU_NOT.
  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD: result = opA + opB;
      ALU_OR:  result = opA | opB;
      ALU_AND: result = opA & opB;
      ALU_NOT: result = ~opA;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two valid/ready requesters and holds the
// registered result until the owning requester takes it.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no result held; any valid request is accepted
// ST_RESP | result held for owner; new accept only on owner handshake
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_opA,
  input  logic [WIDTH-1:0] req0_opB,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_opA,
  input  logic [WIDTH-1:0] req1_opB,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  logic [0:0]       state;
  logic             owner;
  logic             lastGrant;
  logic             grantSel;
  logic             ownerRspReady;
  logic             acceptAllowed;
  logic             accept;
  logic [1:0]       aluCtrl;
  logic [WIDTH-1:0] aluOpA;
  logic [WIDTH-1:0] aluOpB;
  logic [WIDTH-1:0] aluResult;

  // Grant selection and accept qualification; a held result blocks new
  // work unless its owner is taking it this cycle.
  always_comb begin
    ownerRspReady = owner ? rsp1_ready : rsp0_ready;
    acceptAllowed = (state == ST_IDLE) || ownerRspReady;
    if (req0_valid && req1_valid) begin
      grantSel = RR_ENABLE ? ~lastGrant : 1'b0;
    end else begin
      grantSel = req1_valid;
    end
    accept     = (req0_valid || req1_valid) && acceptAllowed;
    req0_ready = accept && !grantSel;
    req1_ready = accept && grantSel;
    aluCtrl    = grantSel ? req1_ctrl : req0_ctrl;
    aluOpA     = grantSel ? req1_opA  : req0_opA;
    aluOpB     = grantSel ? req1_opB  : req0_opB;
  end

  ula #(.WIDTH(WIDTH)) uUla (
    .ctrl   (aluCtrl),
    .opA    (aluOpA),
    .opB    (aluOpB),
    .result (aluResult)
  );

  // FSM, result register and round-robin history; a new accept takes
  // precedence over the plain return to idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      lastGrant  <= 1'b1;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (accept) begin
      state      <= ST_RESP;
      owner      <= grantSel;
      lastGrant  <= grantSel;
      rsp_result <= aluResult;
      rsp_zero   <= (aluOpA == aluOpB);
    end else if ((state == ST_RESP) && ownerRspReady) begin
      state <= ST_IDLE;
    end
  end

  // Response valids follow the held owner.
  always_comb begin
    busy       = (state == ST_RESP);
    rsp0_valid = busy && !owner;
    rsp1_valid = busy && owner;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one round-robin and one
// fixed-priority instance share all inputs.
module tb_alu_share_arbiter;

  localparam int W = 20;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [1:0]   req0_ctrl, req1_ctrl;
  logic [W-1:0] req0_opA, req0_opB, req1_opA, req1_opB;
  logic         rsp0_ready, rsp1_ready;

  logic         rrReq0Ready, rrReq1Ready, rrRsp0Valid, rrRsp1Valid, rrZero, rrBusy;
  logic [W-1:0] rrResult;
  logic         fpReq0Ready, fpReq1Ready, fpRsp0Valid, fpRsp1Valid, fpZero, fpBusy;
  logic [W-1:0] fpResult;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_share_arbiter #(.WIDTH(W), .RR_ENABLE(1'b1)) dutRr (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(rrReq0Ready), .req0_ctrl(req0_ctrl),
    .req0_opA(req0_opA), .req0_opB(req0_opB),
    .req1_valid(req1_valid), .req1_ready(rrReq1Ready), .req1_ctrl(req1_ctrl),
    .req1_opA(req1_opA), .req1_opB(req1_opB),
    .rsp0_valid(rrRsp0Valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rrRsp1Valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rrResult), .rsp_zero(rrZero), .busy(rrBusy)
  );

  alu_share_arbiter #(.WIDTH(W), .RR_ENABLE(1'b0)) dutFp (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(fpReq0Ready), .req0_ctrl(req0_ctrl),
    .req0_opA(req0_opA), .req0_opB(req0_opB),
    .req1_valid(req1_valid), .req1_ready(fpReq1Ready), .req1_ctrl(req1_ctrl),
    .req1_opA(req1_opA), .req1_opB(req1_opB),
    .rsp0_valid(fpRsp0Valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(fpRsp1Valid), .rsp1_ready(rsp1_ready),
    .rsp_result(fpResult), .rsp_zero(fpZero), .busy(fpBusy)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %0b expected %0b", tag, obs, exp);
      $error("%s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkW(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %05h expected %05h", tag, obs, exp);
      $error("%s observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_ctrl = 2'b00; req1_ctrl = 2'b00;
    req0_opA = '0; req0_opB = '0; req1_opA = '0; req1_opB = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    tick();
    chk1("rst_rsp0v", rrRsp0Valid, 1'b0);
    chk1("rst_rsp1v", rrRsp1Valid, 1'b0);
    chkW("rst_result", rrResult, 20'h00000);
    chk1("rst_zero", rrZero, 1'b0);
    chk1("rst_busy", rrBusy, 1'b0);
    chk1("rst_fp_busy", fpBusy, 1'b0);
    reset = 1'b0;

    // Requester 0 alone: 1 + 1
    req0_valid = 1'b1; req0_ctrl = 2'b00; req0_opA = 20'h00001; req0_opB = 20'h00001;
    #1;
    chk1("t1_req0_ready", rrReq0Ready, 1'b1);
    chk1("t1_req1_ready", rrReq1Ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    chk1("t1_rsp0v", rrRsp0Valid, 1'b1);
    chk1("t1_rsp1v", rrRsp1Valid, 1'b0);
    chkW("t1_result", rrResult, 20'h00002);
    chk1("t1_zero", rrZero, 1'b1);
    chk1("t1_busy", rrBusy, 1'b1);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    chk1("t1_idle_busy", rrBusy, 1'b0);
    chk1("t1_idle_rsp0v", rrRsp0Valid, 1'b0);

    // Backpressure: owner 0 holds result 5 while requester 1 waits
    req0_valid = 1'b1; req0_ctrl = 2'b00; req0_opA = 20'h00002; req0_opB = 20'h00003;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_ctrl = 2'b01; req1_opA = 20'h000F0; req1_opB = 20'h0000F;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("bp_req1_ready", rrReq1Ready, 1'b0);
      chk1("bp_rsp0v", rrRsp0Valid, 1'b1);
      chkW("bp_result", rrResult, 20'h00005);
      chk1("bp_zero", rrZero, 1'b0);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    chk1("bp_release_req1_ready", rrReq1Ready, 1'b1);
    tick();
    rsp0_ready = 1'b0;
    req1_valid = 1'b0;
    chk1("bp_rsp1v", rrRsp1Valid, 1'b1);
    chk1("bp_rsp0v_off", rrRsp0Valid, 1'b0);
    chkW("bp_result1", rrResult, 20'h000FF);
    // Non-owner ready must not release the result
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    chk1("nonowner_rsp1v", rrRsp1Valid, 1'b1);
    chkW("nonowner_result", rrResult, 20'h000FF);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    chk1("bp_idle_busy", rrBusy, 1'b0);

    // Sustained contention: RR alternates 0,1,0,1; FP always grants 0
    req0_valid = 1'b1; req0_ctrl = 2'b10; req0_opA = 20'hF0F0F; req0_opB = 20'h0FF00;
    req1_valid = 1'b1; req1_ctrl = 2'b00; req1_opA = 20'h12345; req1_opB = 20'h12345;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("rr_req0_ready", rrReq0Ready, (i % 2) == 0);
      chk1("rr_req1_ready", rrReq1Ready, (i % 2) == 1);
      chk1("fp_req0_ready", fpReq0Ready, 1'b1);
      chk1("fp_req1_ready", fpReq1Ready, 1'b0);
      tick();
      if ((i % 2) == 0) begin
        chk1("rr_rsp0v", rrRsp0Valid, 1'b1);
        chkW("rr_result_and", rrResult, 20'h00F00);
        chk1("rr_zero_and", rrZero, 1'b0);
      end else begin
        chk1("rr_rsp1v", rrRsp1Valid, 1'b1);
        chkW("rr_result_add", rrResult, 20'h2468A);
        chk1("rr_zero_add", rrZero, 1'b1);
      end
      chk1("fp_rsp0v", fpRsp0Valid, 1'b1);
      chkW("fp_result", fpResult, 20'h00F00);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk1("rr_drain_busy", rrBusy, 1'b0);

    // NOT ignores opB, then back-to-back wrapping add
    req1_valid = 1'b1; req1_ctrl = 2'b11; req1_opA = 20'hFFC00; req1_opB = 20'h12345;
    tick();
    req1_valid = 1'b0;
    chk1("not_rsp1v", rrRsp1Valid, 1'b1);
    chkW("not_result", rrResult, 20'h003FF);
    chk1("not_zero", rrZero, 1'b0);
    req0_valid = 1'b1; req0_ctrl = 2'b00; req0_opA = 20'hFFFFF; req0_opB = 20'h00001;
    #1;
    chk1("wrap_req0_ready", rrReq0Ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    chk1("wrap_rsp0v", rrRsp0Valid, 1'b1);
    chkW("wrap_result", rrResult, 20'h00000);
    chk1("wrap_zero", rrZero, 1'b0);
    tick();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset while busy, together with an owner handshake and a pending request
    req0_valid = 1'b1; req0_ctrl = 2'b00; req0_opA = 20'h00003; req0_opB = 20'h00004;
    tick();
    req0_valid = 1'b0;
    chk1("prerst_busy", rrBusy, 1'b1);
    chkW("prerst_result", rrResult, 20'h00007);
    reset = 1'b1;
    rsp0_ready = 1'b1;
    req1_valid = 1'b1; req1_ctrl = 2'b01; req1_opA = 20'h00010; req1_opB = 20'h00001;
    tick();
    reset = 1'b0;
    rsp0_ready = 1'b0;
    chk1("midrst_rsp0v", rrRsp0Valid, 1'b0);
    chk1("midrst_rsp1v", rrRsp1Valid, 1'b0);
    chkW("midrst_result", rrResult, 20'h00000);
    chk1("midrst_zero", rrZero, 1'b0);
    chk1("midrst_busy", rrBusy, 1'b0);
    req0_valid = 1'b1; req0_ctrl = 2'b01; req0_opA = 20'h00A00; req0_opB = 20'h0000B;
    #1;
    chk1("postrst_tie_req0", rrReq0Ready, 1'b1);
    chk1("postrst_tie_req1", rrReq1Ready, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk1("postrst_rsp0v", rrRsp0Valid, 1'b1);
    chkW("postrst_result", rrResult, 20'h00A0B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
